// File: rtl/fft_frame_feeder_if.sv
`timescale 1ns/1ps
// Avalon-ST sink bus from the frame feeder (master) into the FFT core (slave).
interface fft_frame_feeder_if #(parameter int DATA_W = 12);
    logic                     fft_sink_valid;
    logic                     fft_sink_ready;
    logic                     fft_sink_sop;
    logic                     fft_sink_eop;
    logic signed [DATA_W-1:0] fft_sink_real;
    logic signed [DATA_W-1:0] fft_sink_imag;
    logic [1:0]               fft_sink_error;

    modport master (
        output fft_sink_valid, fft_sink_sop, fft_sink_eop,
        output fft_sink_real, fft_sink_imag, fft_sink_error,
        input  fft_sink_ready
    );

    modport slave (
        input  fft_sink_valid, fft_sink_sop, fft_sink_eop,
        input  fft_sink_real, fft_sink_imag, fft_sink_error,
        output fft_sink_ready
    );
endinterface

// File: rtl/fft_frame_feeder.sv
`timescale 1ns/1ps
// Buffers mono samples in a show-ahead FIFO and streams whole FFT_PTS-beat
// frames with sop/eop into the FFT sink, starting only once a full frame is held.
module fft_frame_feeder #(
    parameter int DATA_W     = 12,
    parameter int FFT_PTS    = 1024,
    parameter int PTS_W      = 13,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_enable,
    input  logic                         sample_valid,
    input  logic signed [DATA_W-1:0]     sample_data,
    input  logic                         overflow_clr,
    fft_frame_feeder_if.master           sink,
    output logic [PTS_W-1:0]             fft_pts,
    output logic                         fft_inverse,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [CNT_W-1:0]             frame_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (FFT_PTS > 1) ? $clog2(FFT_PTS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_n;

    logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic wr_en, rd_en, last_beat;
    logic valid, sop, eop;

    // Space is judged on the registered level, so a same-cycle pop never frees room.
    assign wr_en     = sample_valid && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign rd_en     = valid && sink.fft_sink_ready;
    assign last_beat = (beat_cnt == BEAT_W'(FFT_PTS - 1));

    assign sink.fft_sink_valid = valid;
    assign sink.fft_sink_sop   = sop;
    assign sink.fft_sink_eop   = eop;
    assign sink.fft_sink_imag  = '0;
    assign sink.fft_sink_error = 2'b00;
    assign fft_pts             = PTS_W'(FFT_PTS);
    assign fft_inverse         = 1'b0;

    // Show-ahead head; forced to zero when empty so reset presents a clean 0.
    assign sink.fft_sink_real = (fifo_level != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            overflow    <= 1'b0;
            beat_cnt    <= '0;
            frame_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (sample_valid && !wr_en) overflow <= 1'b1;
            else if (overflow_clr)      overflow <= 1'b0;
            if (rd_en) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (last_beat) frame_count <= frame_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Leaving STREAM always lands in IDLE for at least one cycle between frames.
    always_comb begin
        state_n = state;
        valid   = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_enable && (fifo_level >= LVL_W'(FFT_PTS))) state_n = STREAM;
            end
            STREAM: begin
                valid = 1'b1;
                sop   = (beat_cnt == '0);
                eop   = last_beat;
                if (sink.fft_sink_ready && last_beat) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fft_frame_feeder.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fft_frame_feeder;
    localparam int DATA_W = 12, FFT_PTS = 1024, PTS_W = 13, FIFO_DEPTH = 2048, CNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_enable = 1'b0;
    logic sample_valid = 1'b0;
    logic overflow_clr = 1'b0;
    logic signed [DATA_W-1:0] sample_data = '0;
    logic [PTS_W-1:0] fft_pts;
    logic             fft_inverse;
    logic [11:0]      fifo_level;
    logic             overflow;
    logic [CNT_W-1:0] frame_count;

    fft_frame_feeder_if #(.DATA_W(DATA_W)) bus();

    fft_frame_feeder #(
        .DATA_W(DATA_W), .FFT_PTS(FFT_PTS), .PTS_W(PTS_W),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_enable(frame_enable),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .overflow_clr(overflow_clr), .sink(bus), .fft_pts(fft_pts),
        .fft_inverse(fft_inverse), .fifo_level(fifo_level),
        .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_idx = 0;
    int xfers = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n consecutive samples; only the first n_push are expected to come out.
    task automatic write_ramp(input int base, input int n, input int n_push);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = DATA_W'(base + i);
            if (i < n_push) begin
                b.data = DATA_W'(base + i);
                b.sop  = (exp_idx == 0);
                b.eop  = (exp_idx == FFT_PTS - 1);
                exp_q.push_back(b);
                exp_idx = (exp_idx + 1) % FFT_PTS;
            end
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int c = 0;
        while (frame_count !== CNT_W'(target) && c < budget) begin
            tick();
            c++;
        end
        check(name, frame_count, target);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int c = 0;
        while (xfers < target && c < budget) begin
            tick();
            c++;
        end
        check(name, xfers, target);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"}, bus.fft_sink_valid, 0);
        check({tag, " sop"}, bus.fft_sink_sop, 0);
        check({tag, " eop"}, bus.fft_sink_eop, 0);
        check({tag, " level"}, fifo_level, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " frame_count"}, frame_count, 0);
        check({tag, " real"}, bus.fft_sink_real, 0);
        check({tag, " fft_pts"}, fft_pts, 1024);
        check({tag, " inverse"}, fft_inverse, 0);
        check({tag, " error"}, bus.fft_sink_error, 0);
        check({tag, " imag"}, bus.fft_sink_imag, 0);
    endtask

    // Monitor: every transfer pops one expected beat; a stalled beat must not change.
    initial begin : monitor
        beat_t e;
        logic hold_pend;
        logic [DATA_W+2:0] hold_val;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend)
                    check("hold", {bus.fft_sink_valid, bus.fft_sink_real, bus.fft_sink_sop, bus.fft_sink_eop}, hold_val);
                if (bus.fft_sink_valid && bus.fft_sink_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: unexpected beat real=%0d, none expected", bus.fft_sink_real);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {bus.fft_sink_real, bus.fft_sink_sop, bus.fft_sink_eop}, {e.data, e.sop, e.eop});
                    end
                    xfers++;
                end
                hold_pend = bus.fft_sink_valid && !bus.fft_sink_ready;
                hold_val  = {bus.fft_sink_valid, bus.fft_sink_real, bus.fft_sink_sop, bus.fft_sink_eop};
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        int start;
        bus.fft_sink_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Reset mid-run with data buffered.
        write_ramp(0, 10, 0);
        check("t1 level before reset", fifo_level, 10);
        reset_n = 1'b0;
        #1;
        check_reset_state("t1");
        tick();
        reset_n = 1'b1;
        tick();
        exp_idx = 0;

        // Single frame, no backpressure.
        bus.fft_sink_ready = 1'b1;
        frame_enable = 1'b1;
        write_ramp(0, 1024, 1024);
        check("t2 level full", fifo_level, 1024);
        check("t2 valid low at full", bus.fft_sink_valid, 0);
        tick();
        check("t2 valid rises", bus.fft_sink_valid, 1);
        check("t2 first sop", bus.fft_sink_sop, 1);
        wait_frames("t2 frame_count", 1, 2000);
        check("t2 level after", fifo_level, 0);
        check("t2 valid after", bus.fft_sink_valid, 0);
        check("t2 queue drained", exp_q.size(), 0);

        // Backpressure: ready alternates 1,0 from the first valid cycle.
        bus.fft_sink_ready = 1'b0;
        write_ramp(0, 1024, 1024);
        cyc = 0;
        while (!bus.fft_sink_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("t3 valid start", bus.fft_sink_valid, 1);
        cyc = 0;
        while (bus.fft_sink_valid && cyc < 5000) begin
            bus.fft_sink_ready = (cyc % 2 == 0);
            tick();
            cyc++;
        end
        check("t3 frame cycles", cyc, 2047);
        check("t3 frame_count", frame_count, 2);
        check("t3 queue drained", exp_q.size(), 0);

        // Overflow and sticky clear.
        bus.fft_sink_ready = 1'b0;
        frame_enable = 1'b0;
        write_ramp(0, 2049, 2048);
        check("t4 level full", fifo_level, 2048);
        check("t4 overflow set", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t4 overflow cleared", overflow, 0);
        sample_valid = 1'b1;
        sample_data  = 12'sd1000;
        overflow_clr = 1'b1;
        tick();
        sample_valid = 1'b0;
        overflow_clr = 1'b0;
        check("t4 set beats clear", overflow, 1);
        check("t4 level unchanged", fifo_level, 2048);
        bus.fft_sink_ready = 1'b1;
        frame_enable = 1'b1;
        wait_frames("t4 drain frames", 4, 5000);
        check("t4 level drained", fifo_level, 0);
        check("t4 queue drained", exp_q.size(), 0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;

        // Enable drop mid-frame.
        frame_enable = 1'b0;
        write_ramp(100, 2048, 2048);
        check("t5 level full", fifo_level, 2048);
        start = xfers;
        frame_enable = 1'b1;
        wait_xfers("t5 beat 300", start + 300, 2000);
        frame_enable = 1'b0;
        wait_frames("t5 frame completes", 5, 2000);
        check("t5 level half", fifo_level, 1024);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5 valid stays low", bus.fft_sink_valid, 0);
        end
        frame_enable = 1'b1;
        wait_frames("t5 second frame", 6, 2000);
        check("t5 level drained", fifo_level, 0);
        check("t5 queue drained", exp_q.size(), 0);

        // Reset mid-frame, then a fresh frame.
        start = xfers;
        write_ramp(512, 1024, 1024);
        wait_xfers("t6 beat 500", start + 500, 2000);
        reset_n = 1'b0;
        #1;
        check_reset_state("t6");
        exp_q.delete();
        exp_idx = 0;
        tick();
        reset_n = 1'b1;
        tick();
        write_ramp(3000, 1024, 1024);
        wait_frames("t6 frame_count", 1, 2000);
        check("t6 level drained", fifo_level, 0);
        check("t6 queue drained", exp_q.size(), 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
